// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receive-drain FSM state encoding and a
// small saturating-counter helper.
package uart_pkg;

  localparam int UART_WIDTH = 8;

  // Drain FSM encoding, kept as plain constants for legacy compatibility.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ULD  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  localparam int DROP_CNT_W = 8;

  typedef logic [1:0]            drain_state_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + drop_cnt_t'(1);
  endfunction

endpackage

// File: rtl/rx_fifo_ram.sv
// Storage array for the receive FIFO: one synchronous write port and one
// asynchronous read port so the head entry is visible show-ahead.
module rx_fifo_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  rxclk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the array has no reset; the pointers alone decide which entries are valid,
  // and leaving it unreset lets it map onto RAM or LUT storage.
  always_ff @(posedge rxclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive drain and FIFO: unloads bytes from the UART holding register into
// a 2**DEPTH_LOG2-entry FIFO. Define RXFIFO_OVF_EN for overflow status/counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = UART_WIDTH
) (
  input  logic                  rxclk,
  input  logic                  reset,
  input  logic                  rx_empty,
  input  logic [WIDTH-1:0]      rx_data,
  output logic                  uld_rx_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_count
`ifdef RXFIFO_OVF_EN
  ,
  input  logic                  ovf_clr,
  output logic                  ovf,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  drain_state_t          state;
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic                  capt;
  logic                  pop;
  logic                  wr_accept;
  logic                  drop;

  // Drain FSM: one unload strobe per byte, capture on the following cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      uld_rx_data <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_empty) begin
            uld_rx_data <= 1'b1;
            state       <= ST_ULD;
          end
        end
        ST_ULD: begin
          uld_rx_data <= 1'b0;
          state       <= ST_CAPT;
        end
        ST_CAPT: begin
          state <= ST_IDLE;
        end
        default: begin
          uld_rx_data <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // A pop in the capture cycle frees a slot, so a full FIFO still accepts the byte.
  assign capt      = (state == ST_CAPT);
  assign pop       = rd_en && !fifo_empty;
  assign wr_accept = capt && (!fifo_full || pop);
  assign drop      = capt && fifo_full && !pop;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
    end
  end

  rx_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_ram (
    .rxclk (rxclk),
    .we    (wr_accept),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rd_data)
  );

`ifdef RXFIFO_OVF_EN
  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= ovf_clr ? drop_cnt_t'(1) : sat_inc(drop_cnt);
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end
`else
  logic drop_unused;
  assign drop_unused = drop;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: UART holding-register model, queue-based
// reference FIFO, table-driven single-byte timing and directed corner sequences.
module tb_uart_rx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        uld_rx_data;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic [DL:0] fifo_count;
`ifdef RXFIFO_OVF_EN
  logic        ovf_clr = 1'b0;
  logic        ovf;
  logic [7:0]  drop_cnt;
`endif

  uart_rx_fifo #(.DEPTH_LOG2(DL), .WIDTH(8)) dut (
    .rxclk       (rxclk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .uld_rx_data (uld_rx_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count)
`ifdef RXFIFO_OVF_EN
    ,
    .ovf_clr     (ovf_clr),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 rxclk = ~rxclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART side: bytes waiting in the holding register chain, and the unloaded byte.
  logic [7:0] uart_q[$];
  logic [7:0] cap_byte;
  bit         pending;
  int         unloads;
  // Reference FIFO contents and overflow status.
  logic [7:0] m_q[$];
  bit         m_ovf;
  int         m_drop;

  task automatic send(input logic [7:0] b);
    uart_q.push_back(b);
    rx_empty = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_count"}, fifo_count, m_q.size());
    check({tag, "_empty"}, fifo_empty, m_q.size() == 0);
    check({tag, "_full"},  fifo_full,  m_q.size() == DEPTH);
    if (m_q.size() > 0) check({tag, "_head"}, rd_data, m_q[0]);
`ifdef RXFIFO_OVF_EN
    check({tag, "_ovf"},  ovf,      m_ovf);
    check({tag, "_drop"}, drop_cnt, m_drop);
`endif
  endtask

  // One clock: inputs applied now, model updated from the rules after the edge.
  task automatic step(input bit rd, input bit clr);
    logic prev_uld;
    bit   do_pop, do_wr;
    prev_uld = uld_rx_data;
    rd_en = rd;
`ifdef RXFIFO_OVF_EN
    ovf_clr = clr;
`endif
    @(posedge rxclk);
    #1;
    do_pop = rd && (m_q.size() > 0);
    do_wr  = pending && ((m_q.size() - int'(do_pop)) < DEPTH);
    if (pending && !do_wr) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop >= 255) ? 255 : m_drop + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_wr)  m_q.push_back(cap_byte);
    pending = 1'b0;
    if (prev_uld) begin
      check("unload_has_byte", uart_q.size() > 0, 1);
      if (uart_q.size() > 0) begin
        cap_byte = uart_q.pop_front();
        rx_data  = cap_byte;
        pending  = 1'b1;
        unloads++;
      end
    end
    rx_empty = (uart_q.size() == 0);
    rd_en = 1'b0;
`ifdef RXFIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    check("uld_single_cycle", prev_uld && uld_rx_data, 0);
    compare_model("step");
  endtask

  task automatic tick();
    step(1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (uart_q.size() == 0 && !pending) break;
      tick();
    end
    check(name, (uart_q.size() == 0) && !pending, 1);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, rd_data, exp);
    step(1'b1, 1'b0);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < DEPTH; i++) send(8'(i));
    wait_drain("fill_drain", 200);
  endtask

  typedef struct {
    bit         rd;
    logic       exp_uld;
    logic       exp_empty;
    logic [4:0] exp_count;
    bit         chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       t1[6];
  logic [7:0] exp40[$];
  logic [7:0] got40[$];
  int         base_unloads;

  initial begin
    t1[0] = '{rd: 0, exp_uld: 1, exp_empty: 1, exp_count: 0, chk_data: 0, exp_data: 8'h00};
    t1[1] = '{rd: 0, exp_uld: 0, exp_empty: 1, exp_count: 0, chk_data: 0, exp_data: 8'h00};
    t1[2] = '{rd: 0, exp_uld: 0, exp_empty: 0, exp_count: 1, chk_data: 1, exp_data: 8'h41};
    t1[3] = '{rd: 0, exp_uld: 0, exp_empty: 0, exp_count: 1, chk_data: 1, exp_data: 8'h41};
    t1[4] = '{rd: 1, exp_uld: 0, exp_empty: 1, exp_count: 0, chk_data: 0, exp_data: 8'h00};
    t1[5] = '{rd: 1, exp_uld: 0, exp_empty: 1, exp_count: 0, chk_data: 0, exp_data: 8'h00};

    // Reset values.
    repeat (2) @(posedge rxclk);
    #1;
    check("rst_uld",   uld_rx_data, 0);
    check("rst_empty", fifo_empty,  1);
    check("rst_full",  fifo_full,   0);
    check("rst_count", fifo_count,  0);
`ifdef RXFIFO_OVF_EN
    check("rst_ovf",  ovf,      0);
    check("rst_drop", drop_cnt, 0);
`endif
    @(posedge rxclk);
    #1;
    reset = 1'b0;

    // 1: single byte, cycle-exact timing.
    send(8'h41);
    for (int i = 0; i < 6; i++) begin
      step(t1[i].rd, 1'b0);
      check($sformatf("t1[%0d]_uld", i),   uld_rx_data, t1[i].exp_uld);
      check($sformatf("t1[%0d]_empty", i), fifo_empty,  t1[i].exp_empty);
      check($sformatf("t1[%0d]_count", i), fifo_count,  t1[i].exp_count);
      if (t1[i].chk_data) check($sformatf("t1[%0d]_data", i), rd_data, t1[i].exp_data);
    end

    // 2: fill to 16, then drain in order.
    fill_seq();
    check("t2_full",  fifo_full,  1);
    check("t2_count", fifo_count, 16);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("t2_pop%0d", i), 8'(i));
    check("t2_empty", fifo_empty, 1);

    // 3: overflow, bytes still unloaded, contents untouched.
    fill_seq();
    base_unloads = unloads;
    for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i));
    wait_drain("t3_drain", 50);
    check("t3_unloads", unloads - base_unloads, 3);
    check("t3_count",   fifo_count, 16);
    check("t3_head",    rd_data,    8'h00);
`ifdef RXFIFO_OVF_EN
    check("t3_ovf",  ovf,      1);
    check("t3_drop", drop_cnt, 3);
    step(1'b0, 1'b1);
    check("t3_clr_ovf",  ovf,      0);
    check("t3_clr_drop", drop_cnt, 0);
    // Drop and clear in the same cycle: the drop wins.
    send(8'h77);
    for (int i = 0; i < 10 && !pending; i++) tick();
    check("t3_capt_reached", pending, 1);
    step(1'b0, 1'b1);
    check("t3_coinc_ovf",  ovf,      1);
    check("t3_coinc_drop", drop_cnt, 1);
    for (int i = 0; i < 260; i++) send(8'(i));
    wait_drain("t3_sat_drain", 1000);
    check("t3_sat_drop", drop_cnt, 255);
    step(1'b0, 1'b1);
    check("t3_sat_clr", drop_cnt, 0);
`endif

    // 4: full FIFO, pop in the capture cycle of 0xA5.
    send(8'hA5);
    for (int i = 0; i < 10 && !pending; i++) tick();
    check("t4_capt_reached", pending, 1);
    step(1'b1, 1'b0);
    check("t4_count", fifo_count, 16);
    check("t4_full",  fifo_full,  1);
`ifdef RXFIFO_OVF_EN
    check("t4_no_drop", drop_cnt, 0);
`endif
    for (int i = 1; i < DEPTH; i++) pop_check($sformatf("t4_pop%0d", i), 8'(i));
    pop_check("t4_tail", 8'hA5);
    check("t4_empty", fifo_empty, 1);

    // 5: 40 random bytes streamed with random reads; pointers wrap.
    for (int i = 0; i < 40; i++) begin
      exp40.push_back(8'($urandom_range(0, 255)));
      send(exp40[i]);
    end
    for (int i = 0; i < 1000 && got40.size() < 40; i++) begin
      bit rd;
      rd = ($urandom_range(0, 1) == 1);
      if (rd && !fifo_empty) got40.push_back(rd_data);
      step(rd, 1'b0);
    end
    check("t5_nread", got40.size(), 40);
    for (int i = 0; i < 40 && i < got40.size(); i++)
      check($sformatf("t5_byte%0d", i), got40[i], exp40[i]);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("t5_empty_rd_count", fifo_count, 0);

    // 6: reset while in ULD.
    send(8'h3C);
    for (int i = 0; i < 5 && !uld_rx_data; i++) tick();
    check("t6_uld_seen", uld_rx_data, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_uld_drop",  uld_rx_data, 0);
    check("t6_count",     fifo_count,  0);
    check("t6_empty",     fifo_empty,  1);
    uart_q.delete();
    m_q.delete();
    pending  = 1'b0;
    m_ovf    = 1'b0;
    m_drop   = 0;
    rx_empty = 1'b1;
    @(posedge rxclk);
    #1;
    reset = 1'b0;
    tick();
    tick();
    check("t6_idle_uld", uld_rx_data, 0);
    send(8'h5A);
    wait_drain("t6_drain", 20);
    check("t6_recount", fifo_count, 1);
    check("t6_redata",  rd_data,    8'h5A);
    step(1'b1, 1'b0);

    // Random soak against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && uart_q.size() < 2) send(8'($urandom_range(0, 255)));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
